// File: rtl/urs_pkg.sv
// ============================================================================
// Module : urs_pkg
// Brief  : Mode encodings shared by the universal register and its bit cells.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package urs_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'd1;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'd2;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'd3;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'd5;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'd6;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'd7;

endpackage

`default_nettype wire

// File: rtl/universal_reg_bit.sv
// ============================================================================
// Module : universal_reg_bit
// Brief  : One storage bit: mode-selected next value, reset/set/enable
//          priority and the flop itself.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module universal_reg_bit
  import urs_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic              load_bit,
  input  logic              shl_bit,
  input  logic              shr_bit,
  input  logic              inc_bit,
  input  logic              dec_bit,
  input  logic              rol_bit,
  input  logic              ror_bit,
  output logic              q
);

  logic r_q;
  logic w_next;

  always_comb begin
    w_next = r_q;
    case (mode)
      MODE_HOLD: w_next = r_q;
      MODE_LOAD: w_next = load_bit;
      MODE_SHL:  w_next = shl_bit;
      MODE_SHR:  w_next = shr_bit;
      MODE_INC:  w_next = inc_bit;
      MODE_DEC:  w_next = dec_bit;
      MODE_ROL:  w_next = rol_bit;
      MODE_ROR:  w_next = ror_bit;
      default:   w_next = r_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_q <= RST_BIT;
    end else if (!set_n) begin
      r_q <= 1'b1;
    end else if (en) begin
      r_q <= w_next;
    end
  end

  assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/universal_reg_rs.sv
// ============================================================================
// Module : universal_reg_rs
// Brief  : WIDTH-bit register/shifter/counter with sync active-low reset and
//          set, clock enable and a registered carry/borrow flag.
//          Define URS_SAT_EN to make INC/DEC saturate instead of wrap.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module universal_reg_rs
  import urs_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              set_n,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_l,
  input  logic              sin_r,
  output logic [WIDTH-1:0]  q,
  output logic              co
);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_dec;
  logic             w_all_ones;
  logic             w_zero;
  logic             r_co;

  assign w_all_ones = &w_q;
  assign w_zero     = ~|w_q;

  assign w_shl = {w_q[WIDTH-2:0], sin_r};
  assign w_shr = {sin_l, w_q[WIDTH-1:1]};
  assign w_rol = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
  assign w_ror = {w_q[0], w_q[WIDTH-1:1]};

`ifdef URS_SAT_EN
  // Pin at the rail; co still flags the attempted overflow/underflow.
  assign w_inc = w_all_ones ? w_q : w_q + WIDTH'(1);
  assign w_dec = w_zero     ? w_q : w_q - WIDTH'(1);
`else
  assign w_inc = w_q + WIDTH'(1);
  assign w_dec = w_q - WIDTH'(1);
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    universal_reg_bit #(
      .RST_BIT (RST_VAL[i])
    ) u_bit (
      .clk      (clk),
      .reset_n  (reset_n),
      .set_n    (set_n),
      .en       (en),
      .mode     (mode),
      .load_bit (d[i]),
      .shl_bit  (w_shl[i]),
      .shr_bit  (w_shr[i]),
      .inc_bit  (w_inc[i]),
      .dec_bit  (w_dec[i]),
      .rol_bit  (w_rol[i]),
      .ror_bit  (w_ror[i]),
      .q        (w_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_co <= 1'b0;
    end else if (!set_n) begin
      r_co <= 1'b0;
    end else if (en) begin
      case (mode)
        MODE_HOLD: r_co <= 1'b0;
        MODE_LOAD: r_co <= 1'b0;
        MODE_SHL:  r_co <= w_q[WIDTH-1];
        MODE_SHR:  r_co <= w_q[0];
        MODE_INC:  r_co <= w_all_ones;
        MODE_DEC:  r_co <= w_zero;
        MODE_ROL:  r_co <= w_q[WIDTH-1];
        MODE_ROR:  r_co <= w_q[0];
        default:   r_co <= 1'b0;
      endcase
    end
  end

  assign q  = w_q;
  assign co = r_co;

endmodule

`default_nettype wire

// File: tb/tb_universal_reg_rs.sv
// ============================================================================
// Module : tb_universal_reg_rs
// Brief  : Scoreboard bench driving 8-, 2- and 16-bit instances in lockstep
//          against an arithmetic reference model. Honours URS_SAT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_universal_reg_rs;
  import urs_pkg::*;

`ifdef URS_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  localparam logic [7:0]  RV8  = 8'h00;
  localparam logic [1:0]  RV2  = 2'b10;
  localparam logic [15:0] RV16 = 16'h1234;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        set_n = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  mode = MODE_HOLD;
  logic [15:0] d = '0;
  logic        sin_l = 1'b0;
  logic        sin_r = 1'b0;
  logic [7:0]  q8;
  logic [1:0]  q2;
  logic [15:0] q16;
  logic        co8, co2, co16;

  always #5 clk = ~clk;

  universal_reg_rs #(.WIDTH(8), .RST_VAL(RV8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .set_n(set_n), .en(en), .mode(mode),
    .d(d[7:0]), .sin_l(sin_l), .sin_r(sin_r), .q(q8), .co(co8));

  universal_reg_rs #(.WIDTH(2), .RST_VAL(RV2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .set_n(set_n), .en(en), .mode(mode),
    .d(d[1:0]), .sin_l(sin_l), .sin_r(sin_r), .q(q2), .co(co2));

  universal_reg_rs #(.WIDTH(16), .RST_VAL(RV16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .set_n(set_n), .en(en), .mode(mode),
    .d(d), .sin_l(sin_l), .sin_r(sin_r), .q(q16), .co(co16));

  typedef struct {
    logic [15:0] q8, q2, q16;
    logic        co8, co2, co16;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_total = 0;

  // Model state per instance: index 0 = 8-bit, 1 = 2-bit, 2 = 16-bit.
  int unsigned m_q[3];
  bit          m_co[3];
  int          m_w[3]  = '{8, 2, 16};
  int unsigned m_rv[3] = '{32'(RV8), 32'(RV2), 32'(RV16)};

  function automatic void model_step(
      input int w, input int unsigned rv, input int unsigned q, input bit co,
      input bit rn, input bit sn, input bit e, input int m, input int unsigned dv,
      input bit sl, input bit sr, output int unsigned nq, output bit nco);
    int unsigned mask = (32'd1 << w) - 1;
    int unsigned msb  = (q >> (w - 1)) & 1;
    int unsigned lsb  = q & 1;
    nq  = q;
    nco = co;
    if (!rn) begin
      nq = rv; nco = 1'b0;
    end else if (!sn) begin
      nq = mask; nco = 1'b0;
    end else if (e) begin
      case (m)
        0: begin nq = q;                                   nco = 1'b0; end
        1: begin nq = dv & mask;                           nco = 1'b0; end
        2: begin nq = ((q << 1) | int'(sr)) & mask;        nco = bit'(msb); end
        3: begin nq = (int'(sl) << (w - 1)) | (q >> 1);    nco = bit'(lsb); end
        4: begin
          nco = (q == mask);
          nq  = (SAT && q == mask) ? q : (q + 1) & mask;
        end
        5: begin
          nco = (q == 0);
          nq  = (SAT && q == 0) ? q : (q - 1) & mask;
        end
        6: begin nq = ((q << 1) | msb) & mask;             nco = bit'(msb); end
        default: begin nq = (lsb << (w - 1)) | (q >> 1);   nco = bit'(lsb); end
      endcase
    end
  endfunction

  task automatic cyc(input bit rn, input bit sn, input bit e, input logic [2:0] m,
                     input logic [15:0] dv, input bit sl, input bit sr);
    exp_t        x;
    int unsigned nq;
    bit          nco;
    @(negedge clk);
    reset_n = rn; set_n = sn; en = e; mode = m; d = dv; sin_l = sl; sin_r = sr;
    for (int k = 0; k < 3; k++) begin
      model_step(m_w[k], m_rv[k], m_q[k], m_co[k], rn, sn, e, int'(m), 32'(dv),
                 sl, sr, nq, nco);
      m_q[k]  = nq;
      m_co[k] = nco;
    end
    x.q8 = m_q[0][15:0]; x.q2 = m_q[1][15:0]; x.q16 = m_q[2][15:0];
    x.co8 = m_co[0]; x.co2 = m_co[1]; x.co16 = m_co[2];
    sb.push_back(x);
  endtask

  function automatic void check(input string name, input logic [15:0] act,
                                input logic [15:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endfunction

  // Monitor: each edge the registers present a new value; compare against
  // the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("q8",   {8'h00, q8},      e.q8);
        check("co8",  {15'h0, co8},     {15'h0, e.co8});
        check("q2",   {14'h0, q2},      e.q2);
        check("co2",  {15'h0, co2},     {15'h0, e.co2});
        check("q16",  q16,              e.q16);
        check("co16", {15'h0, co16},    {15'h0, e.co16});
      end
    end
  end

  initial begin
    int budget;
    for (int k = 0; k < 3; k++) begin m_q[k] = 0; m_co[k] = 1'b0; end

    // Reset wins over simultaneous set and load.
    cyc(0, 0, 1, MODE_LOAD, 16'h00A5, 0, 0);
    // Load then hold with en low while INC requested.
    cyc(1, 1, 1, MODE_LOAD, 16'h003C, 0, 0);
    repeat (3) cyc(1, 1, 0, MODE_INC, 16'h0000, 0, 0);
    // Increment across all-ones, then decrement below zero.
    cyc(1, 1, 1, MODE_LOAD, 16'h00FE, 0, 0);
    repeat (2) cyc(1, 1, 1, MODE_INC, 16'h0000, 0, 0);
    cyc(1, 1, 1, MODE_LOAD, 16'h0000, 0, 0);
    cyc(1, 1, 1, MODE_DEC, 16'h0000, 0, 0);
    // Shift and rotate corner patterns.
    cyc(1, 1, 1, MODE_LOAD, 16'h8081, 0, 0);
    cyc(1, 1, 1, MODE_SHL, 16'h0000, 0, 0);
    cyc(1, 1, 1, MODE_SHR, 16'h0000, 1, 0);
    cyc(1, 1, 1, MODE_ROR, 16'h0000, 0, 0);
    cyc(1, 1, 1, MODE_ROL, 16'h0000, 0, 0);
    // Set mid-count, then reset alongside set.
    cyc(1, 1, 1, MODE_LOAD, 16'h0010, 0, 0);
    repeat (2) cyc(1, 1, 1, MODE_INC, 16'h0000, 0, 0);
    cyc(1, 0, 1, MODE_INC, 16'h0000, 0, 0);
    cyc(0, 0, 1, MODE_INC, 16'h0000, 0, 0);
    // Pure holds with en=1 clear co.
    cyc(1, 1, 1, MODE_HOLD, 16'h0000, 0, 0);

    for (int i = 0; i < 10000; i++) begin
      cyc($urandom_range(0, 63) != 0, $urandom_range(0, 63) != 0,
          $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
          16'($urandom), 1'($urandom), 1'($urandom));
    end

    budget = 0;
    while (sb.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    if (sb.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
